// File: rtl/dmem_resp.sv
// Data-side memory responder: word RAM plus a timer/interrupt register block, with misaligned/unmapped flagging.
// Latency: RAM accesses complete WAIT_CYCLES+1 cycles after accept; register and error accesses complete 1 cycle after accept.
// Backpressure: one transaction in flight; req_i is ignored outside IDLE, so the core holds its request until ready_o.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   req_i, we_i           request valid and store/load select (sampled in IDLE)
//   addr_i32, wdata_i32   byte address and store data (sampled with req_i)
//   ready_o               one-cycle completion pulse
//   rdata_o32             load data, valid with ready_o, held otherwise
//   err_o                 misaligned/unmapped flag, qualified by ready_o
//   irq_o                 registered level interrupt: match_flag & irq_en
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] wdata_i32,
  output logic        ready_o,
  output logic [31:0] rdata_o32,
  output logic        err_o,
  output logic        irq_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {CLS_RAM, CLS_REG, CLS_ERR} cls_e;

  // Register offsets within the block (address bits [3:2]).
  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_CMP    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Misalignment is checked first so a misaligned RAM/register address is still an error.
  // MMIO_BASE is 16-byte aligned, so comparing bits [31:4] covers BASE..BASE+0xC exactly.
  function automatic cls_e classify(input logic [31:0] a);
    if (a[1:0] != 2'b00)              return CLS_ERR;
    if (a < RAM_BYTES)                return CLS_RAM;
    if (a[31:4] == MMIO_BASE[31:4])   return CLS_REG;
    return CLS_ERR;
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         cnt_q, cnt_d;
  cls_e               req_cls;

  logic               ready_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rd_data;

  // Timer/interrupt register block
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               tmr_en_q, tmr_en_d;
  logic               irq_en_q, irq_en_d;
  logic               match_q, match_d;
  logic               irq_q;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               commit;
  logic               ram_wr;
  logic               reg_wr;
  logic               match_hit;

  assign req_cls = classify(addr_i32);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          cls_d   = req_cls;
          we_d    = we_i;
          idx_d   = addr_i32[IDX_W+1:2];
          sel_d   = addr_i32[3:2];
          wdata_d = wdata_i32;
          if (req_cls == CLS_RAM && WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data for the transaction entering RESP. On the accept edge (zero wait
  // states or REG/ERR) the _d values already carry the fresh request, in WAIT
  // they hold the latched one, so one mux serves both paths.
  always_comb begin
    rd_data = '0;
    case (cls_d)
      CLS_RAM: rd_data = mem_q[idx_d];
      CLS_REG: begin
        case (sel_d)
          REG_COUNT:  rd_data = count_q;
          REG_CMP:    rd_data = cmp_q;
          REG_CTRL:   rd_data = {30'd0, irq_en_q, tmr_en_q};
          REG_STATUS: rd_data = {31'd0, match_q};
          default:    rd_data = '0;
        endcase
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_ERR;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      // RESP always lasts one cycle, so entering it yields a single-cycle pulse.
      ready_q <= (state_d == ST_RESP);
      err_q   <= (state_d == ST_RESP) && (cls_d == CLS_ERR);
      if (state_d == ST_RESP) begin
        rdata_q <= rd_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write commit (edge that ends RESP) and timer
  // ---------------------------------------------------------------------------
  assign commit    = (state_q == ST_RESP) && we_q;
  assign ram_wr    = commit && (cls_q == CLS_RAM);
  assign reg_wr    = commit && (cls_q == CLS_REG);
  assign match_hit = tmr_en_q && (count_q == cmp_q);

  always_comb begin
    count_d  = tmr_en_q ? count_q + 32'd1 : count_q;
    cmp_d    = cmp_q;
    tmr_en_d = tmr_en_q;
    irq_en_d = irq_en_q;
    match_d  = match_q;
    if (reg_wr) begin
      case (sel_q)
        REG_COUNT:  count_d = wdata_q;
        REG_CMP:    cmp_d   = wdata_q;
        REG_CTRL: begin
          tmr_en_d = wdata_q[0];
          irq_en_d = wdata_q[1];
        end
        REG_STATUS: if (wdata_q[0]) match_d = 1'b0;
        default: ;
      endcase
    end
    // Placed after the W1C so a coincident match keeps the flag set.
    if (match_hit) match_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      tmr_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      tmr_en_q <= tmr_en_d;
      irq_en_q <= irq_en_d;
      match_q  <= match_d;
      irq_q    <= match_q & irq_en_q;
    end
  end

  // RAM contents survive reset; a reset coinciding with RESP drops the pending store.
  always_ff @(posedge clk_i) begin
    if (!reset_i && ram_wr) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ready_o   = ready_q;
  assign rdata_o32 = rdata_q;
  assign err_o     = err_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  localparam logic [31:0] R_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] R_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] R_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] R_STATUS = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;

  // Instance A: default parameters (WAIT_CYCLES=2)
  logic        req_a, we_a, ready_a, err_a, irq_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  // Instance B: zero wait states
  logic        req_b, we_b, ready_b, err_b, irq_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_resp u_dut_a (
    .clk_i(clk), .reset_i(reset), .req_i(req_a), .we_i(we_a),
    .addr_i32(addr_a), .wdata_i32(wdata_a), .ready_o(ready_a),
    .rdata_o32(rdata_a), .err_o(err_a), .irq_o(irq_a)
  );

  dmem_resp #(.WAIT_CYCLES(0)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .req_i(req_b), .we_i(we_b),
    .addr_i32(addr_b), .wdata_i32(wdata_b), .ready_o(ready_b),
    .rdata_o32(rdata_b), .err_o(err_b), .irq_o(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction: drive a request in IDLE, hold it until ready_o, then drop it.
  // lat=1 means ready_o is visible right after the accept edge; lat=0 means timeout.
  task automatic xact(input bit sel_b, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    @(posedge clk); #1;
    if (sel_b) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    end
    lat = 0; rdata = '0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((sel_b ? ready_b : ready_a) === 1'b1) begin
        lat   = k;
        rdata = sel_b ? rdata_b : rdata_a;
        err   = sel_b ? err_b : err_a;
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic run(input string tag, input bit sel_b, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_lat, input bit exp_err,
                     input bit chk_data, input logic [31:0] exp_data);
    logic [31:0] rd;
    logic        er;
    int          lt;
    xact(sel_b, we, addr, wdata, rd, er, lt);
    check({tag, ".lat"}, 32'(lt), 32'(exp_lat));
    check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    if (chk_data) check({tag, ".data"}, rd, exp_data);
  endtask

  initial begin
    int rise_j;
    int pulses;

    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst.ready", {31'd0, ready_a}, 32'd0);
    check("rst.rdata", rdata_a, 32'd0);
    check("rst.err",   {31'd0, err_a}, 32'd0);
    check("rst.irq",   {31'd0, irq_a}, 32'd0);
    run("rst.cmp", 0, 0, R_CMP, 0, 1, 0, 1, 32'hFFFF_FFFF);

    // RAM latency with default wait states
    run("ram.st10", 0, 1, 32'h10, 32'hDEAD_BEEF, 3, 0, 0, 0);
    run("ram.st20", 0, 1, 32'h20, 32'h1234_5678, 3, 0, 0, 0);
    run("ram.st00", 0, 1, 32'h00, 32'h0000_1111, 3, 0, 0, 0);
    run("ram.ld10", 0, 0, 32'h10, 0, 3, 0, 1, 32'hDEAD_BEEF);

    // Zero wait states, then a request held high through RESP
    run("w0.st3c", 1, 1, 32'h3C, 32'hCAFE_F00D, 1, 0, 0, 0);
    @(posedge clk); #1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h3C;
    @(posedge clk); #1;
    check("w0.hold.ready", {31'd0, ready_b}, 32'd1);
    check("w0.hold.data",  rdata_b, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check("w0.hold.noreaccept", {31'd0, ready_b}, 32'd0);
    check("w0.hold.rdata_kept", rdata_b, 32'hCAFE_F00D);
    req_b = 1'b0;

    // Error cases; the unmapped store aliases word 0 if decoded wrongly
    run("err.misal",  0, 0, 32'h11,        0,            1, 1, 1, 32'd0);
    run("err.unmap",  0, 1, 32'h0000_1000, 32'h0BAD_0BAD, 1, 1, 1, 32'd0);
    run("err.ramchk", 0, 0, 32'h00,        0,            3, 0, 1, 32'h0000_1111);
    run("err.ld10",   0, 0, 32'h10,        0,            3, 0, 1, 32'hDEAD_BEEF);

    // Timer interrupt: COUNT=0 commits on the first edge of the loop below;
    // COUNT reaches 20 after 20 more edges, the flag sets on the next, irq one later.
    run("tmr.cmp",   0, 1, R_CMP,   32'd20,        1, 0, 0, 0);
    run("tmr.ctrl",  0, 1, R_CTRL,  32'hFFFF_FFFF, 1, 0, 0, 0);
    run("tmr.count", 0, 1, R_COUNT, 32'd0,         1, 0, 0, 0);
    rise_j = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (rise_j == 0 && irq_a === 1'b1) rise_j = j;
    end
    check("tmr.irq_rise", 32'(rise_j), 32'd23);
    run("tmr.ctrl_rd", 0, 0, R_CTRL,   0, 1, 0, 1, 32'd3);
    run("tmr.stat1",   0, 0, R_STATUS, 0, 1, 0, 1, 32'd1);
    run("tmr.w1c",     0, 1, R_STATUS, 32'd1, 1, 0, 0, 0);
    run("tmr.stat0",   0, 0, R_STATUS, 0, 1, 0, 1, 32'd0);
    check("tmr.irq_low", {31'd0, irq_a}, 32'd0);

    // W1C landing on the match edge: COUNT=0 commits at E, W1C commits at E+2
    // where the pre-edge COUNT is 1 == CMP.
    run("tmr.cmp1",   0, 1, R_CMP,    32'd1, 1, 0, 0, 0);
    run("tmr.cnt0",   0, 1, R_COUNT,  32'd0, 1, 0, 0, 0);
    run("tmr.w1cm",   0, 1, R_STATUS, 32'd1, 1, 0, 0, 0);
    run("tmr.setwin", 0, 0, R_STATUS, 0,     1, 0, 1, 32'd1);
    check("tmr.irq_kept", {31'd0, irq_a}, 32'd1);
    run("tmr.w1c2",   0, 1, R_STATUS, 32'd1, 1, 0, 0, 0);

    // Wrap-around: FFFF_FFFE commits, two idle edges, the load then reads 0
    run("wrap.st", 0, 1, R_COUNT, 32'hFFFF_FFFE, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    run("wrap.ld", 0, 0, R_COUNT, 0, 1, 0, 1, 32'd0);
    run("wrap.ctrl", 0, 0, R_CTRL, 0, 1, 0, 1, 32'd3);

    // Reset during WAIT of a store to 0x20
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hAAAA_5555;
    @(posedge clk); #1;
    req_a = 1'b0;
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready_a === 1'b1) pulses++;
      if (k == 1) reset = 1'b0;
    end
    check("mid.no_ready", 32'(pulses), 32'd0);
    check("mid.rdata",    rdata_a, 32'd0);
    check("mid.err",      {31'd0, err_a}, 32'd0);
    check("mid.irq",      {31'd0, irq_a}, 32'd0);
    run("mid.ld20", 0, 0, 32'h20, 0, 3, 0, 1, 32'h1234_5678);
    run("mid.cmp",  0, 0, R_CMP,  0, 1, 0, 1, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
